alu_issue_stage: RTL and testbench

- Upstream issue and capture stage for the 8-bit combinational ALU.
- Buffers operand/opcode commands in a small FIFO and drives the ALU's A, B and ALU_Sel inputs from registers.
- Captures ALU_Out and CarryOut one cycle later and presents each result on a valid/ready output interface.
- Gives the purely combinational ALU a registered, flow-controlled datapath.

---
 rtl/alu_issue_stage.sv | 136 +++++++++++++
 tb/tb_alu_issue_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue/capture stage for the 8-bit combinational ALU: command FIFO, registered ALU inputs, captured results.
// Optional divide-by-zero trap on the result path is enabled with `define ALU_DIVZ_TRAP_EN.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  input  logic [3:0]    in_sel,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_sel,
  input  logic [7:0]    alu_out,
  input  logic          alu_carry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_result,
  output logic          out_carry,
  output logic [3:0]    out_sel,
  output logic          out_divz,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_t;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid and the payload stay stable until that edge, and ready never depends on valid.
  state_t          state;
  state_t          state_nxt;
  logic [19:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            capture;
  logic            release_out;
  logic            divz_hit;
  logic [7:0]      cap_result;

  // in_ready looks only at the registered count, so a same-cycle pop cannot raise it.
  assign in_ready   = (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_count = count;

`ifdef ALU_DIVZ_TRAP_EN
  assign divz_hit = (alu_sel == 4'b0011) && (alu_b == 8'h00);
`else
  assign divz_hit = 1'b0;
`endif
  assign cap_result = divz_hit ? 8'hFF : alu_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = ISSUE;
      ISSUE:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = (count != '0) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE:  pop = (count != '0);
      ISSUE: capture = 1'b1;
      HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          pop         = (count != '0);
        end
      end
      default: ;
    endcase
  end

  // Storage needs no reset: count/pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_sel, in_a, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_sel    <= '0;
      out_divz   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (pop) {alu_sel, alu_a, alu_b} <= mem[rd_ptr];
      if (capture) begin
        out_result <= cap_result;
        out_carry  <= alu_carry;
        out_sel    <= alu_sel;
        out_divz   <= divz_hit;
        out_valid  <= 1'b1;
      end else if (release_out) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU stub, vector table, directed corner sequences, random stream.
// Expected results come from an in-order queue filled at command acceptance.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic [3:0]    in_sel;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_sel;
  logic [7:0]    alu_out;
  logic          alu_carry;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_result;
  logic          out_carry;
  logic [3:0]    out_sel;
  logic          out_divz;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_sel(out_sel), .out_divz(out_divz),
    .fifo_count(fifo_count)
  );

  // 8-bit ALU behaviour; carry is always the carry-out of A+B. Division by zero yields 0 here.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [7:0] r;
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (sel)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a * b;
      4'd3:  r = (b == 8'd0) ? 8'd0 : a / b;
      4'd4:  r = {a[6:0], 1'b0};
      4'd5:  r = {1'b0, a[7:1]};
      4'd6:  r = {a[6:0], a[7]};
      4'd7:  r = {a[0], a[7:1]};
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = a ^ b;
      4'd11: r = ~(a | b);
      4'd12: r = ~(a & b);
      4'd13: r = ~(a ^ b);
      4'd14: r = (a > b) ? 8'd1 : 8'd0;
      default: r = (a == b) ? 8'd1 : 8'd0;
    endcase
    return {s[8], r};
  endfunction

  always_comb {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  // Expected record: {divz, sel, carry, result}
  function automatic logic [13:0] exp_rec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [8:0] cr;
    logic [7:0] r;
    logic       d;
    cr = alu_fn(a, b, sel);
    r  = cr[7:0];
    d  = 1'b0;
`ifdef ALU_DIVZ_TRAP_EN
    if (sel == 4'b0011 && b == 8'd0) begin
      r = 8'hFF;
      d = 1'b1;
    end
`endif
    return {d, sel, cr[8], r};
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] res;
    logic       c;
    logic       divz;
  } vec_t;

  vec_t        vecs [9];
  logic [13:0] exp_q [$];
  int          fire_cyc [$];
  logic [7:0]  res_log [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        prev_hold = 1'b0;
  logic [13:0] prev_out  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called with inputs already driven after a falling edge; observes, updates the model, waits one cycle.
  task automatic tick();
    logic [13:0] got;
    #1;
    got = {out_divz, out_sel, out_carry, out_result};
    if (prev_hold) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_stable", 32'(got), 32'(prev_out));
    end
    check("fifo_bound", 32'(fifo_count <= CW'(DEPTH)), 32'd1);
    if (in_valid && in_ready) exp_q.push_back(exp_rec(in_a, in_b, in_sel));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_result", 32'(got), 32'h3FFF_0000);
      else check("result_order", 32'(got), 32'(exp_q.pop_front()));
      fire_cyc.push_back(cyc);
      res_log.push_back(out_result);
    end
    check("capacity", 32'(exp_q.size() <= DEPTH + 1), 32'd1);
    prev_hold = out_valid && !out_ready;
    prev_out  = got;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_vec(input int i);
    int n;
    in_a = vecs[i].a; in_b = vecs[i].b; in_sel = vecs[i].sel;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("vec_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("vec_latency", 32'(n), 32'd2);
    check("vec_result", 32'(out_result), 32'(vecs[i].res));
    check("vec_carry", 32'(out_carry), 32'(vecs[i].c));
    check("vec_sel", 32'(out_sel), 32'(vecs[i].sel));
    check("vec_divz", 32'(out_divz), 32'(vecs[i].divz));
    tick();
  endtask

  task automatic drain(input int budget);
    int n;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    vecs[0] = '{8'd200, 8'd100, 4'd0,  8'd44,  1'b1, 1'b0};
    vecs[1] = '{8'd15,  8'd3,   4'd3,  8'd5,   1'b0, 1'b0};
    vecs[2] = '{8'h81,  8'h00,  4'd6,  8'h03,  1'b0, 1'b0};
    vecs[3] = '{8'h0F,  8'hF0,  4'd9,  8'hFF,  1'b0, 1'b0};
    vecs[4] = '{8'd10,  8'd3,   4'd1,  8'd7,   1'b0, 1'b0};
    vecs[5] = '{8'hFF,  8'h0F,  4'd8,  8'h0F,  1'b1, 1'b0};
`ifdef ALU_DIVZ_TRAP_EN
    vecs[6] = '{8'd10,  8'd0,   4'd3,  8'hFF,  1'b0, 1'b1};
`else
    vecs[6] = '{8'd10,  8'd0,   4'd3,  8'h00,  1'b0, 1'b0};
`endif
    vecs[7] = '{8'd20,  8'd7,   4'd2,  8'h8C,  1'b0, 1'b0};
    vecs[8] = '{8'h96,  8'h20,  4'd14, 8'h01,  1'b0, 1'b0};

    // Reset
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_alu_regs", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("rst_out_regs", 32'({out_result, out_sel, out_carry, out_divz}), 32'd0);
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 9; i++) run_vec(i);

    // Ordering across opcodes
    res_log.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd15; in_b = 8'd3; in_sel = 4'b0011; tick();
    in_a = 8'h81; in_b = 8'h00; in_sel = 4'b0110; tick();
    in_a = 8'h0F; in_b = 8'hF0; in_sel = 4'b1001; tick();
    in_valid = 1'b0;
    for (int n = 0; n < 20 && res_log.size() < 3; n++) tick();
    check("order_count", 32'(res_log.size()), 32'd3);
    if (res_log.size() == 3) begin
      check("order_0", 32'(res_log[0]), 32'd5);
      check("order_1", 32'(res_log[1]), 32'h03);
      check("order_2", 32'(res_log[2]), 32'hFF);
    end
    drain(20);

    // Backpressure: fill with out_ready low
    res_log.delete(); fire_cyc.delete();
    out_ready = 1'b0; acc = 0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1;
      in_a = 8'(acc * 10 + 1); in_b = 8'(acc + 2); in_sel = 4'(acc);
      #1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_fifo_count", 32'(fifo_count), 32'd4);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_first_result", 32'(out_result), 32'd3);
    for (int j = 0; j < 3; j++) tick();

    // Full FIFO, HOLD released and new command offered in the same cycle
    in_valid = 1'b1; in_a = 8'd77; in_b = 8'd5; in_sel = 4'd1; out_ready = 1'b1;
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_fifo_count", 32'(fifo_count), 32'd4);
    tick();
    #1;
    check("full_after_pop", 32'(fifo_count), 32'd3);
    check("full_valid_clear", 32'(out_valid), 32'd0);
    check("full_ready_back", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("full_refill", 32'(fifo_count), 32'd4);
    drain(40);
    check("bp_total", 32'(res_log.size()), 32'd6);
    for (int j = 1; j < fire_cyc.size(); j++)
      check("bp_gap", 32'(fire_cyc[j] - fire_cyc[j-1]), 32'd2);

    // Reset mid-operation
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_a = 8'(j + 40); in_b = 8'(j); in_sel = 4'(j + 8);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    check("mid_pre_count", 32'(fifo_count), 32'd3);
    #1; rst = 1'b1; #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_fifo_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    prev_hold = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    for (int j = 0; j < 6; j++) tick();
    check("mid_no_stale", 32'(out_valid), 32'd0);

    // Random stream against the queue model
    for (int j = 0; j < 400; j++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom_range(0, 255));
      in_b      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      in_sel    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
